// File: rtl/adau_pkg.sv
// adau_pkg: shared state/owner enums and command field positions for the ADAU SPI arbiter
package adau_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE} state_e;
  typedef enum logic {OWN_INIT, OWN_USR} owner_e;
  localparam int RW_BIT       = 24;
  localparam int REG_ADDR_MSB = 23;
  localparam int REG_ADDR_LSB = 8;
  localparam int DATA_MSB     = 7;
  localparam int DATA_LSB     = 0;
endpackage

// File: rtl/adau_spi_arbiter.sv
// adau_spi_arbiter: fixed-priority init/user arbiter feeding one SPI master, one command outstanding
module adau_spi_arbiter
  import adau_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] init_command,
  input  logic        init_valid,
  output logic        init_ready,
  input  logic        init_done,
  input  logic [31:0] usr_command,
  input  logic        usr_valid,
  output logic        usr_ready,
  output logic [7:0]  usr_rdata,
  output logic        usr_rdata_valid,
  output logic [31:0] spi_command,
  output logic        spi_command_valid,
  input  logic        spi_ready,
  input  logic        spi_done,
  input  logic [7:0]  spi_rdata,
  output logic        busy,
  output logic        timeout_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);
  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] cmd_q, cmd_d;
  logic [7:0] rdata_q, rdata_d;
  logic rv_q, rv_d, to_q, to_d;
  logic idle, usr_xfer;
  assign idle              = state_q == S_IDLE;
  assign init_ready        = idle;
  assign usr_ready         = idle & init_done & ~init_valid;
  assign usr_xfer          = usr_valid & usr_ready;
  assign spi_command       = cmd_q;
  assign spi_command_valid = state_q == S_ISSUE;
  assign busy              = ~idle;
  assign usr_rdata         = rdata_q;
  assign usr_rdata_valid   = rv_q;
  assign timeout_err       = to_q;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    rdata_d = rdata_q;
    rv_d    = 1'b0;
    to_d    = 1'b0;
    if (idle && (init_valid || usr_xfer)) begin
      state_d = S_ISSUE;
      cmd_d   = init_valid ? init_command : usr_command;
      owner_d = init_valid ? OWN_INIT : OWN_USR;
      rd_d    = cmd_d[RW_BIT];
    end
    if (state_q == S_ISSUE && spi_ready) begin
      state_d = S_WAIT_DONE;
      cnt_d   = '0;
    end
    // completion wins over a timeout landing on the same cycle
    if (state_q == S_WAIT_DONE) begin
      cnt_d   = cnt_q == TERM ? cnt_q : cnt_q + CW'(1);
      state_d = (spi_done || cnt_q == TERM) ? S_IDLE : S_WAIT_DONE;
      rv_d    = spi_done && owner_q == OWN_USR && rd_q;
      rdata_d = rv_d ? spi_rdata : rdata_q;
      to_d    = !spi_done && cnt_q == TERM;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= OWN_INIT;
      rd_q    <= 1'b0;
      cnt_q   <= '0;
      cmd_q   <= '0;
      rdata_q <= '0;
      rv_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      rdata_q <= rdata_d;
      rv_q    <= rv_d;
      to_q    <= to_d;
    end
  end
endmodule

// File: doc/adau_spi_arbiter.md
ADAU_SPI_ARBITER -- requirements
Module: adau_spi_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096: maximum cycles from SPI command acceptance to spi_done before the transaction is abandoned.
REQ-002 Port clk  in  1  single system clock; every register updates on its rising edge.
REQ-003 Port reset  in  1  synchronous, active-high reset.
REQ-004 Port init_command  in  32  command from the codec init sequencer.
REQ-005 Port init_valid  in  1  the init sequencer has a command pending.
REQ-006 Port init_ready  out  1  the arbiter accepts init_command this cycle.
REQ-007 Port init_done  in  1  the init sequence is complete; the user port is enabled.
REQ-008 Port usr_command  in  32  runtime register access, e.g. volume control or readback.
REQ-009 Port usr_valid / usr_ready  in / out  1 / 1  user-port handshake.
REQ-010 Port usr_rdata  out  8  read data from the last user read.
REQ-011 Port usr_rdata_valid  out  1  one-cycle pulse when usr_rdata is updated.
REQ-012 Port spi_command  out  32  command to the SPI master, registered.
REQ-013 Port spi_command_valid / spi_ready  out / in  1 / 1  SPI master handshake.
REQ-014 Port spi_done  in  1  one-cycle pulse from the SPI master when a transfer completes.
REQ-015 Port spi_rdata  in  8  last byte shifted in; valid when spi_done is high.
REQ-016 Port busy  out  1  high whenever the state is not IDLE.
REQ-017 Port timeout_err  out  1  one-cycle pulse when a transaction times out.

Function
REQ-018 Command format: bits [31:24] hold the chip-address/R-W byte, with bit 24 = 1 meaning read; bits [23:8] hold the register address; bits [7:0] hold the write data.
REQ-019 A transfer on any handshake occurs when valid and ready are both high in the same cycle.
REQ-020 FSM states: IDLE, ISSUE and WAIT_DONE.
REQ-021 IDLE:
- init_ready = 1.
- usr_ready = init_done AND NOT init_valid. The init port has fixed priority; the user port is blocked until init_done is high.
REQ-022 IDLE -> ISSUE on any requester transfer:
- Latch the command into spi_command.
- Record the owner (INIT or USR) and whether bit 24 was set.
REQ-023 ISSUE:
- spi_command_valid = 1 and spi_command is held stable.
- On spi_ready, go to WAIT_DONE and clear the timeout counter.
REQ-024 WAIT_DONE, on spi_done:
- Go to IDLE.
- If the owner is USR and the command was a read, load usr_rdata <= spi_rdata and pulse usr_rdata_valid the next cycle.
REQ-025 WAIT_DONE, timeout: the counter increments every cycle; when it reaches TIMEOUT_CYCLES-1 without spi_done, pulse timeout_err, go to IDLE and leave usr_rdata unchanged.
REQ-026 A spi_done arriving in the same cycle as the timeout terminal count counts as completion: no timeout_err is raised.
REQ-027 spi_done outside WAIT_DONE is ignored.
REQ-028 Both ready outputs are 0 outside IDLE, so at most one command is outstanding.
REQ-029 Back-to-back operation: the next request may be accepted in the cycle after returning to IDLE, giving a minimum of 3 cycles of arbiter overhead per command.
REQ-030 Init reads (bit 24 set) are issued normally, but their read data is discarded.
REQ-031 The timeout counter is $clog2(TIMEOUT_CYCLES) bits wide and never wraps; it saturates at terminal count.

Reset
REQ-032 On reset:
- State = IDLE.
- spi_command = 0, spi_command_valid = 0.
- usr_rdata = 0, usr_rdata_valid = 0.
- timeout_err = 0, busy = 0.
- Counter and owner cleared.
REQ-033 Reset asserted mid-transaction abandons the transaction within one cycle, with no rdata pulse and no error pulse.

Structure
REQ-034 A shared package adau_pkg holds:
- the state enum;
- the command field positions (RW_BIT = 24, REG_ADDR_MSB/LSB = 23/8, DATA_MSB/LSB = 7/0);
- the owner enum.
REQ-035 Single module, no sub-modules. The timeout counter is inline; a sub-module is not warranted.

Verification
REQ-036 Scenario: init_done = 0, init_valid = 1 with 32'h00_4000_01, and usr_valid = 1 simultaneously -> init is granted; usr_ready stays 0; spi_command = 32'h00_4000_01.
REQ-037 Scenario: init_done = 1, user write 32'h00_4023_e7 -> spi_command_valid asserts the cycle after acceptance; busy stays high until spi_done; no usr_rdata_valid pulse.
REQ-038 Scenario: user read 32'h01_4023_00, with spi_rdata = 8'hA5 at spi_done -> usr_rdata = 8'hA5 with a single-cycle usr_rdata_valid.
REQ-039 Scenario: TIMEOUT_CYCLES = 16 and spi_done never arrives -> one timeout_err pulse 16 cycles after SPI acceptance; the arbiter returns to IDLE and the next request is accepted.
REQ-040 Scenario: spi_done coincides with the timeout terminal count -> no timeout_err; a read completes normally.
REQ-041 Scenario: reset asserted during WAIT_DONE -> all outputs reach their reset values the next cycle; a late spi_done is ignored.
